// File: rtl/conv_pkg.sv
// Shared constants for the small conv/pool datapath: image geometry,
// output word length and the default bias applied to conv results.
package conv_pkg;

  localparam int WORD_LENGTH   = 8;
  localparam int IMAGE_SIZE    = 28;
  localparam int KERNEL_SIZE   = 5;
  localparam int CONV_OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int POOL_OUT_SIZE = CONV_OUT_SIZE / 2;
  localparam int DEFAULT_BIAS  = 14;
  localparam int DEFAULT_SHIFT = 4;

  // Address width for a memory of 'depth' entries, never narrower than 1 bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer for 2x2 pooling: holds the horizontal max of each
// column pair from the even row until the odd row consumes it.
// Entries are individual flops so that reset can clear them all at once.
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = POOL_OUT_SIZE,
  parameter int WIDTH = 16,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] entry_view [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q;
      logic [WIDTH-1:0] entry_d;

      // Load this entry only when it is the addressed write target
      always_comb begin
        entry_d = entry_q;
        if (wr_en && (wr_addr == AW'(gi))) begin
          entry_d = wr_data;
        end
      end

      // Entry storage, cleared on reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign entry_view[gi] = entry_q;
    end
  endgenerate

  // Combinational read so the pooled max is formed in the accepting cycle
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = entry_view[i];
      end
    end
  end

endmodule

// File: rtl/relu_maxpool.sv
// Bias + ReLU + 2x2 max-pool + requantization over a raster-ordered conv
// output map. One pooled value is emitted one cycle after each sample that
// lands on an odd row and odd column.
module relu_maxpool
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = CONV_OUT_SIZE,
  parameter int BIAS   = DEFAULT_BIAS,
  parameter int SHIFT  = DEFAULT_SHIFT,
  parameter int OUT_W  = WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         data_out,
  output logic                     out_last
);

  localparam int CW   = addr_bits(IMG_W);
  localparam int HALF = IMG_W / 2;
  localparam int AW   = addr_bits(HALF);

  localparam logic [CW-1:0]     LAST_IDX = CW'(IMG_W - 1);
  localparam logic [DATA_W:0]   BIAS_EXT = (DATA_W + 1)'(BIAS);
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] QMAX     = DATA_W'((1 << OUT_W) - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] pair_q, pair_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [OUT_W-1:0]  data_out_q, data_out_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] relu_val;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] pmax;
  logic [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]  qsat;
  logic              lb_wr;
  logic              fire;
  logic [AW-1:0]     lb_addr;

  // Bias add in one extra bit, then fold saturation and ReLU together:
  // any negative sum clamps to 0, positive overflow clamps to the max.
  always_comb begin
    sum = {data_in[DATA_W-1], data_in} + BIAS_EXT;
    if (sum[DATA_W]) begin
      relu_val = '0;
    end else if (sum[DATA_W-1]) begin
      relu_val = POS_MAX;
    end else begin
      relu_val = sum[DATA_W-1:0];
    end
  end

  // Horizontal pair max, vertical max against the line buffer, requantize.
  // All operands are non-negative so unsigned compares are sufficient.
  always_comb begin
    hmax    = (pair_q > relu_val) ? pair_q : relu_val;
    pmax    = (hmax > lb_rd) ? hmax : lb_rd;
    shifted = pmax >> SHIFT;
    qsat    = (shifted > QMAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    lb_addr = AW'(col_q >> 1);
    lb_wr   = in_valid && !row_q[0] && col_q[0];
    fire    = in_valid && row_q[0] && col_q[0];
  end

  // Raster position tracking and pair capture; idle cycles leave state alone
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_valid_d = fire;
    out_last_d  = fire && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    data_out_d  = fire ? qsat : data_out_q;
    if (in_valid) begin
      if (!col_q[0]) begin
        pair_d = relu_val;
      end
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      data_out_q  <= data_out_d;
    end
  end

  pool_line_buf #(
    .DEPTH (HALF),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed + randomized bench for relu_maxpool at default parameters.
// A frame-level model computes each pooled value from the four raw samples.
module tb_relu_maxpool;

  localparam int W     = 24;
  localparam int NPIX  = W * W;
  localparam int BIASV = 14;
  localparam int SHFT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [15:0] data_in;
  logic              out_valid;
  logic [7:0]        data_out;
  logic              out_last;

  int n_cmp = 0;
  int n_bad = 0;
  int img [W][W];
  int k;          // raster index of the next accepted sample within a frame
  int last_d;     // value data_out must be holding
  int outs;       // pooled outputs seen since frame_begin
  int lasts;      // out_last pulses seen since frame_begin
  int cap [$];    // captured pooled outputs since frame_begin

  relu_maxpool dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int act(input int x);
    int b;
    b = x + BIASV;
    if (b > 32767) b = 32767;
    if (b < 0) b = 0;
    return b;
  endfunction

  function automatic int pooled(input int i, input int j);
    int m;
    m = act(img[2*i][2*j]);
    if (act(img[2*i][2*j+1])   > m) m = act(img[2*i][2*j+1]);
    if (act(img[2*i+1][2*j])   > m) m = act(img[2*i+1][2*j]);
    if (act(img[2*i+1][2*j+1]) > m) m = act(img[2*i+1][2*j+1]);
    m = m >> SHFT;
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int rand16();
    logic [15:0] rv;
    rv = 16'($urandom);
    return int'($signed(rv));
  endfunction

  task automatic frame_begin();
    outs  = 0;
    lasts = 0;
    cap.delete();
  endtask

  // Present one cycle of input and check the outputs it produces
  task automatic send(input bit v, input int d);
    int r, c, ev, ed, el;
    @(negedge clk);
    in_valid = v;
    data_in  = 16'(d);
    @(posedge clk);
    #1;
    ev = 0; ed = 0; el = 0;
    if (v) begin
      r = k / W;
      c = k % W;
      img[r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        ev = 1;
        ed = pooled(r / 2, c / 2);
        el = (r == W - 1 && c == W - 1) ? 1 : 0;
      end
      k = (k + 1) % NPIX;
    end
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev != 0) begin
      chk("data_out", 32'(data_out), 32'(ed));
      chk("out_last", 32'(out_last), 32'(el));
      last_d = ed;
    end else begin
      chk("data_hold", 32'(data_out), 32'(last_d));
      chk("out_last_idle", 32'(out_last), 32'd0);
    end
    if (out_valid) begin
      outs++;
      cap.push_back(int'(data_out));
    end
    if (out_last) lasts++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'(rand16());
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    k        = 0;
    last_d   = 0;
  endtask

  task automatic frame_counts(input string tag, input int exp_outs, input int exp_lasts);
    chk({tag, "_outs"}, 32'(outs), 32'(exp_outs));
    chk({tag, "_lasts"}, 32'(lasts), 32'(exp_lasts));
  endtask

  task automatic ramp_spots(input string tag);
    chk({tag, "_count"}, 32'(cap.size()), 32'd144);
    if (cap.size() >= 144) begin
      chk({tag, "_first"}, 32'(cap[0]), 32'd2);
      chk({tag, "_last"}, 32'(cap[143]), 32'd36);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'sh1234;
    k        = 0;
    last_d   = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_last", 32'(out_last), 32'd0);
    chk("init_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // All-zero frame
    frame_begin();
    for (int i = 0; i < NPIX; i++) send(1'b1, 0);
    frame_counts("zeros", 144, 1);
    $display("zeros frame: %0d outputs", outs);

    // Ramp frame
    frame_begin();
    for (int i = 0; i < NPIX; i++) send(1'b1, i);
    frame_counts("ramp", 144, 1);
    ramp_spots("ramp");
    $display("ramp frame: %0d outputs", outs);

    // Negative frame, ReLU clamps to zero
    frame_begin();
    for (int i = 0; i < NPIX; i++) send(1'b1, -100);
    frame_counts("neg", 144, 1);
    $display("negative frame: %0d outputs", outs);

    // Positive-max frame, bias add saturates
    frame_begin();
    for (int i = 0; i < NPIX; i++) send(1'b1, 32767);
    frame_counts("max", 144, 1);
    if (cap.size() > 0) chk("max_value", 32'(cap[0]), 32'd255);
    $display("saturating frame: %0d outputs", outs);

    // Ramp with in_valid toggling every cycle
    frame_begin();
    for (int i = 0; i < NPIX; i++) begin
      send(1'b1, i);
      send(1'b0, rand16());
    end
    frame_counts("toggle", 144, 1);
    ramp_spots("toggle");
    $display("toggled ramp frame: %0d outputs", outs);

    // Reset part-way through a frame, then a clean ramp
    for (int i = 0; i < 300; i++) send(1'b1, rand16());
    do_reset();
    frame_begin();
    for (int i = 0; i < NPIX; i++) send(1'b1, i);
    frame_counts("post_rst", 144, 1);
    ramp_spots("post_rst");
    $display("post-reset ramp frame: %0d outputs", outs);

    // Two back-to-back random frames
    frame_begin();
    for (int i = 0; i < 2 * NPIX; i++) send(1'b1, rand16());
    frame_counts("b2b", 288, 2);
    $display("back-to-back frames: %0d outputs", outs);

    // Random frame with random-length gaps, values around zero
    frame_begin();
    for (int i = 0; i < NPIX; i++) begin
      send(1'b1, int'($urandom_range(0, 4000)) - 1500);
      repeat ($urandom_range(0, 3)) send(1'b0, rand16());
    end
    frame_counts("gaps", 144, 1);
    $display("gapped random frame: %0d outputs", outs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
